sonar_capture_ctrl: RTL
=======================

// Module: sonar_capture_ctrl
// PURPOSE
//   Per-frame sonar acquisition sequencer: on each display frame start, swaps the
//   write/read RAM bank, fires a 40 kHz-class differential ping burst, and streams
//   CHANNELS ADC samples into the double-buffered sample RAMs. Also detects the
//   first echo per channel (threshold crossing after a blanking window).
//   Sits between the ADC front-ends and the per-channel SDPB RAMs / LCD renderer.
// PARAMETERS
//   CHANNELS     8     number of ADC channels captured in parallel
//   SAMPLE_W     8     bits per sample
//   ADDR_W       11    sample address width; DEPTH = 2**ADDR_W samples per bank
//   HALF_PERIOD  16    sample strobes per ping half-period (1..255)
//   PING_CYCLES  8     full ping periods per burst (1..255)
//   BLANK        400   first address at which echo triggers are armed
// PORTS
//   clk          in   1                   system clock (all logic)
//   nRST         in   1                   async active-low reset
//   frame_start  in   1                   1-cycle pulse, start of display frame
//   sample_valid in   1                   1-cycle strobe, new sample set present
//   sample_data  in   CHANNELS*SAMPLE_W   ch i at [i*SAMPLE_W +: SAMPLE_W]
//   threshold    in   SAMPLE_W            unsigned echo threshold, shared
//   ping_en      in   1                   0 = capture without driving the burst
//   wr_en        out  1                   RAM write enable (all channels)
//   wr_addr      out  ADDR_W+1            {wr_bank, sample address}
//   wr_data      out  CHANNELS*SAMPLE_W   registered copy of sample_data
//   rd_bank      out  1                   bank the renderer reads (= ~wr_bank)
//   pulse_p      out  1                   transducer drive, positive leg
//   pulse_n      out  1                   transducer drive, negative leg
//   trig_valid   out  CHANNELS            echo found for channel i this frame
//   trig_addr    out  CHANNELS*ADDR_W     address of first echo, ch i
//   busy         out  1                   high from frame_start until capture end
// BEHAVIOUR
//   Reset (async, nRST=0): state IDLE; wr_en=0, wr_addr=0 (wr_bank=0), wr_data=0,
//     rd_bank=1, pulse_p=pulse_n=0, trig_valid=0, trig_addr=0, busy=0, counters 0.
//   FSM: IDLE -> PING -> LISTEN -> IDLE.
//   frame_start (any state, highest priority): wr_bank toggles, addr<=0,
//     trig_valid<=0, prev-sample regs<=0, phase/cycle counters<=0, busy<=1,
//     state<=PING. A sample_valid in the same cycle is dropped (not written).
//   Write path (PING, LISTEN): on sample_valid, wr_en=1 next cycle with wr_addr=
//     {wr_bank,addr} and wr_data=sample_data; addr increments after each write.
//     Latency sample_valid -> wr_en exactly 1 clk; wr_en is a 1-clk pulse.
//   Capture end: write at addr=DEPTH-1 is the last; state<=IDLE, busy<=0; no
//     wrap, further sample_valid ignored until next frame_start.
//   PING: counted in sample_valid strobes. Every HALF_PERIOD strobes pulse_n
//     toggles, pulse_p <= ~new pulse_n (legs always complementary while driving;
//     first half-period: pulse_n=1, pulse_p=0). After 2*PING_CYCLES half-periods,
//     pulse_p=pulse_n=0 and state<=LISTEN. ping_en=0: legs held 0, timing same.
//     Legs are never both 1; both 0 in IDLE/LISTEN.
//   Echo trigger (PING and LISTEN): per channel, on a written sample with addr
//     >= BLANK, prev < threshold and cur >= threshold (unsigned), and
//     trig_valid[i]=0: trig_addr[i]<=addr, trig_valid[i]<=1. First crossing only.
//     prev updates on every written sample regardless of BLANK.
//   rd_bank = ~wr_bank combinationally-registered; changes only on frame_start.
//   Mid-frame frame_start restarts cleanly (partial bank abandoned, burst cut).
// TESTING
//   T1 reset: nRST=0 mid-PING -> all outputs 0, rd_bank=1 same cycle (async).
//   T2 capture: frame_start then 2048 strobes -> 2048 wr_en pulses, addr 0..2047,
//     wr_addr[11]=1, rd_bank=0, busy falls after 2048th write; 2049th ignored.
//   T3 ping: HALF_PERIOD=16, PING_CYCLES=8 -> pulse_n toggles at strobes 0,16..,
//     256 strobes driven, then both legs 0; ping_en=0 -> legs stay 0.
//   T4 echo: thr=128, ch3 ramps 0->255 crossing at addr 350 and 600 -> trig_addr
//     [3]=600, trig_valid[3]=1; second crossing at 900 ignored; others stay 0.
//   T5 collision: frame_start with sample_valid same clk -> no wr_en next clk,
//     bank toggles, next strobe written at addr 0.
//   T6 restart: frame_start at addr 1000 -> addr 0, triggers cleared, new burst.

Source files
------------

// File: rtl/sonar_capture_ctrl.sv
// Per-frame sonar acquisition sequencer: swaps the RAM bank on each frame start,
// fires a differential ping burst and streams ADC samples into the write bank.
module sonar_capture_ctrl #(
    parameter int CHANNELS    = 8,
    parameter int SAMPLE_W    = 8,
    parameter int ADDR_W      = 11,
    parameter int HALF_PERIOD = 16,
    parameter int PING_CYCLES = 8,
    parameter int BLANK       = 400
) (
    input  logic                         clk,
    input  logic                         nRST,
    input  logic                         frame_start,
    input  logic                         sample_valid,
    input  logic [CHANNELS*SAMPLE_W-1:0] sample_data,
    input  logic [SAMPLE_W-1:0]          threshold,
    input  logic                         ping_en,
    output logic                         wr_en,
    output logic [ADDR_W:0]              wr_addr,
    output logic [CHANNELS*SAMPLE_W-1:0] wr_data,
    output logic                         rd_bank,
    output logic                         pulse_p,
    output logic                         pulse_n,
    output logic [CHANNELS-1:0]          trig_valid,
    output logic [CHANNELS*ADDR_W-1:0]   trig_addr,
    output logic                         busy
);

    localparam logic [ADDR_W-1:0] ADDR_LAST   = '1;
    localparam logic [ADDR_W-1:0] BLANK_ADDR  = ADDR_W'(BLANK);
    localparam logic [7:0]        PHASE_LAST  = 8'(HALF_PERIOD - 1);
    localparam logic [8:0]        PING_HALVES = 9'(2 * PING_CYCLES);

    typedef enum logic [1:0] {IDLE, PING, LISTEN} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  addr;
    logic               wr_bank;
    logic [7:0]         phase;
    logic [8:0]         half;
    logic               pol;
    logic               accept;

    // A sample coinciding with frame_start belongs to the abandoned frame.
    assign accept = sample_valid && !frame_start && (state != IDLE);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            addr    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b1;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            pulse_p <= 1'b0;
            pulse_n <= 1'b0;
            busy    <= 1'b0;
            phase   <= '0;
            half    <= '0;
            pol     <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (frame_start) begin
                wr_bank <= ~wr_bank;
                rd_bank <= wr_bank;
                addr    <= '0;
                phase   <= '0;
                half    <= '0;
                pol     <= 1'b0;
                pulse_p <= 1'b0;
                pulse_n <= 1'b0;
                busy    <= 1'b1;
                state   <= PING;
            end else begin
                if (state == PING && !ping_en) begin
                    pulse_p <= 1'b0;
                    pulse_n <= 1'b0;
                end
                if (accept) begin
                    wr_en   <= 1'b1;
                    wr_addr <= {wr_bank, addr};
                    wr_data <= sample_data;
                    addr    <= addr + 1'b1;
                    if (state == PING) begin
                        if (phase == '0 && half == PING_HALVES) begin
                            pulse_p <= 1'b0;
                            pulse_n <= 1'b0;
                            state   <= LISTEN;
                        end else begin
                            // pol keeps burst timing even while the legs are gated off
                            if (phase == '0) begin
                                pol     <= ~pol;
                                pulse_n <= ping_en & ~pol;
                                pulse_p <= ping_en & pol;
                            end
                            if (phase == PHASE_LAST) begin
                                phase <= '0;
                                half  <= half + 1'b1;
                            end else begin
                                phase <= phase + 1'b1;
                            end
                        end
                    end
                    if (addr == ADDR_LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        pulse_p <= 1'b0;
                        pulse_n <= 1'b0;
                    end
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_echo
            logic [SAMPLE_W-1:0] prev_reg;
            logic                trig_valid_reg;
            logic [ADDR_W-1:0]   trig_addr_reg;
            logic [SAMPLE_W-1:0] cur;

            assign cur = sample_data[gi*SAMPLE_W +: SAMPLE_W];

            always_ff @(posedge clk or negedge nRST) begin
                if (!nRST) begin
                    prev_reg       <= '0;
                    trig_valid_reg <= 1'b0;
                    trig_addr_reg  <= '0;
                end else if (frame_start) begin
                    prev_reg       <= '0;
                    trig_valid_reg <= 1'b0;
                end else if (accept) begin
                    prev_reg <= cur;
                    if (addr >= BLANK_ADDR && prev_reg < threshold &&
                        cur >= threshold && !trig_valid_reg) begin
                        trig_valid_reg <= 1'b1;
                        trig_addr_reg  <= addr;
                    end
                end
            end

            assign trig_valid[gi]                  = trig_valid_reg;
            assign trig_addr[gi*ADDR_W +: ADDR_W]  = trig_addr_reg;
        end
    endgenerate

endmodule
